// File: rtl/or_gate_response_checker_pkg.sv
// Shared types and helpers for the OR-gate response checker.
// Holds the sweep FSM state encoding, the golden OR reference function
// and the default sizing constants used by the checker and its users.
package or_gate_response_checker_pkg;

   localparam int N_IN_DEFAULT        = 3;
   localparam int HOLD_CYCLES_DEFAULT = 10;
   localparam int N_IN_MAX            = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Reference OR of a vector; narrower vectors are zero-extended by the caller,
   // which leaves the OR-reduction unchanged.
   function automatic logic golden_or(input logic [N_IN_MAX-1:0] vec);
      return |vec;
   endfunction

endpackage

// File: rtl/or_gate_response_checker.sv
// Exhaustive sweeper/checker for an N-input OR gate: drives every vector in
// ascending order, holds each HOLD_CYCLES cycles, then samples and compares.
// Latency: 2^N_IN * HOLD_CYCLES cycles from accepted start to done; start is ignored while busy.
// Ports: clk/rst (async active-high); start begins a sweep; dut_out is the gate
//   response; stim drives the gate; busy/done/pass give status; err_count and
//   first_err_vec summarise mismatches of the last sweep. All outputs registered.
module or_gate_response_checker
   import or_gate_response_checker_pkg::*;
#(
   parameter int N_IN        = N_IN_DEFAULT,
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            dut_out,
   output logic [N_IN-1:0] stim,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic [N_IN-1:0] first_err_vec
);

   // At least one bit so HOLD_CYCLES=1 still yields a legal counter.
   localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   state_t          state;
   logic [HC_W-1:0] hold_cnt;

   logic            last_hold;
   logic            last_vec;
   logic            mismatch;
   logic [N_IN:0]   err_next;

   always_comb begin
      last_hold = (hold_cnt == HC_W'(HOLD_CYCLES - 1));
      last_vec  = (stim == {N_IN{1'b1}});
      mismatch  = (dut_out != golden_or(N_IN_MAX'(stim)));
      // Error count including the sample taken at this edge; the verdict on
      // the final vector must see its own result.
      err_next  = err_count + (N_IN + 1)'(mismatch);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         stim          <= '0;
         hold_cnt      <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_count     <= '0;
         first_err_vec <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  state         <= DRIVE;
                  stim          <= '0;
                  hold_cnt      <= '0;
                  busy          <= 1'b1;
                  pass          <= 1'b0;
                  err_count     <= '0;
                  first_err_vec <= '0;
               end else begin
                  state <= IDLE;
               end
            end

            DRIVE: begin
               if (last_hold) begin
                  if (mismatch) begin
                     err_count <= err_next;
                     if (err_count == '0) begin
                        first_err_vec <= stim;
                     end
                  end
                  if (last_vec) begin
                     // stim stays at all-ones until the next start.
                     state    <= DONE;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     pass     <= (err_next == '0);
                     hold_cnt <= '0;
                  end else begin
                     stim     <= stim + N_IN'(1);
                     hold_cnt <= '0;
                  end
               end else begin
                  hold_cnt <= hold_cnt + HC_W'(1);
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_or_gate_response_checker.sv
// Self-checking bench for or_gate_response_checker (N_IN=3, HOLD_CYCLES=10).
// The gate under test is a lookup table indexed by stim; expected sweep results
// come from comparing that table against the OR of each vector.
module tb_or_gate_response_checker;

   localparam int N  = 3;
   localparam int H  = 10;
   localparam int NV = 1 << N;
   localparam int HT = NV * H;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          dut_out;
   logic [N-1:0]  stim;
   logic          busy;
   logic          done;
   logic          pass;
   logic [N:0]    err_count;
   logic [N-1:0]  first_err_vec;

   logic [NV-1:0] dut_tbl;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Behavioural gate: output for each input vector comes from dut_tbl.
   assign dut_out = dut_tbl[stim];

   or_gate_response_checker #(.N_IN(N), .HOLD_CYCLES(H)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .dut_out       (dut_out),
      .stim          (stim),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .err_count     (err_count),
      .first_err_vec (first_err_vec)
   );

   // Expected sweep summary: every vector v should yield (v != 0).
   function automatic void model(input logic [NV-1:0] tbl, output int e, output int f, output bit p);
      e = 0;
      f = 0;
      for (int v = 0; v < NV; v++) begin
         bit golden;
         golden = (v != 0);
         if (tbl[v] != golden) begin
            if (e == 0) f = v;
            e++;
         end
      end
      p = (e == 0);
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      dut_tbl = 8'hFE;
      #1;
      checks++;
      if ({stim, busy, done, pass, err_count, first_err_vec} !== '0)
         $display("FAIL reset_async got stim=%0h busy=%b done=%b pass=%b err=%0d first=%0h want all 0",
                  stim, busy, done, pass, err_count, first_err_vec);
      repeat (3) @(negedge clk);
      checks++;
      if ({stim, busy, done, pass, err_count, first_err_vec} !== '0)
         $display("FAIL reset_held got stim=%0h busy=%b done=%b pass=%b err=%0d first=%0h want all 0",
                  stim, busy, done, pass, err_count, first_err_vec);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0)
         $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
   endtask

   // One full sweep. Entered at a negedge. pre_started: acceptance edge already
   // passed. poke_at: cycle index to pulse start mid-sweep (-1 none).
   // start_at_end: raise start for the done cycle and leave it high.
   task automatic do_sweep(input string name, input bit pre_started, input int poke_at,
                           input bit start_at_end);
      int e, f;
      bit p;
      int bad_stim, bad_ctl;
      model(dut_tbl, e, f, p);
      if (!pre_started) begin
         start = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
      start = 1'b0;
      bad_stim = 0;
      bad_ctl = 0;
      for (int k = 0; k < HT; k++) begin
         if (k == poke_at) start = 1'b1;
         if (k == poke_at + 1) start = 1'b0;
         if (start_at_end && k == HT - 1) start = 1'b1;
         checks++;
         if (stim !== N'(k / H)) begin
            if (bad_stim < 4)
               $display("FAIL %s stim_step k=%0d got %0h want %0h", name, k, stim, N'(k / H));
            bad_stim++;
            errors++;
         end
         checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            if (bad_ctl < 4)
               $display("FAIL %s busy_done k=%0d got busy=%b done=%b want 1 0", name, k, busy, done);
            bad_ctl++;
            errors++;
         end
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         $display("FAIL %s done_pulse got done=%b busy=%b want 1 0", name, done, busy);
         errors++;
      end
      checks++;
      if (pass !== p) begin
         $display("FAIL %s pass got %b want %b", name, pass, p);
         errors++;
      end
      checks++;
      if (err_count !== (N + 1)'(e)) begin
         $display("FAIL %s err_count got %0d want %0d", name, err_count, e);
         errors++;
      end
      checks++;
      if (first_err_vec !== N'(f)) begin
         $display("FAIL %s first_err_vec got %0h want %0h", name, first_err_vec, f);
         errors++;
      end
      checks++;
      if (stim !== {N{1'b1}}) begin
         $display("FAIL %s stim_final got %0h want %0h", name, stim, {N{1'b1}});
         errors++;
      end
      if (!start_at_end) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || pass !== p || stim !== {N{1'b1}}) begin
            $display("FAIL %s after_done got done=%b busy=%b pass=%b stim=%0h want 0 0 %b %0h",
                     name, done, busy, pass, stim, p, {N{1'b1}});
            errors++;
         end
      end
   endtask

   task automatic test_correct();
      dut_tbl = 8'hFE;
      do_sweep("correct_or", 1'b0, -1, 1'b0);
   endtask

   task automatic test_stuck0();
      dut_tbl = 8'h00;
      do_sweep("stuck0", 1'b0, -1, 1'b0);
   endtask

   task automatic test_and_gate();
      dut_tbl = 8'h80;
      do_sweep("and_gate", 1'b0, -1, 1'b0);
   endtask

   task automatic test_start_while_busy();
      dut_tbl = 8'h00;
      do_sweep("start_busy", 1'b0, 25, 1'b0);
   endtask

   task automatic test_reset_mid_sweep();
      int seen;
      dut_tbl = 8'h00;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (35) begin
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (stim !== 3'b011 || busy !== 1'b1) begin
         $display("FAIL midsweep_pos got stim=%0h busy=%b want 3 1", stim, busy);
         errors++;
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({stim, busy, done, pass, err_count, first_err_vec} !== '0) begin
         $display("FAIL midsweep_reset got stim=%0h busy=%b done=%b pass=%b err=%0d first=%0h want all 0",
                  stim, busy, done, pass, err_count, first_err_vec);
         errors++;
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (60) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
         $display("FAIL aborted_no_done got %0d active cycles want 0", seen);
         errors++;
      end
      dut_tbl = 8'hFE;
      do_sweep("after_abort", 1'b0, -1, 1'b0);
   endtask

   task automatic test_back_to_back();
      dut_tbl = 8'h00;
      do_sweep("b2b_first", 1'b0, -1, 1'b1);
      dut_tbl = 8'hFE;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || pass !== 1'b0 || err_count !== '0 || done !== 1'b0 ||
          stim !== '0 || first_err_vec !== '0) begin
         $display("FAIL b2b_restart got busy=%b pass=%b err=%0d done=%b stim=%0h first=%0h want 1 0 0 0 0 0",
                  busy, pass, err_count, done, stim, first_err_vec);
         errors++;
      end
      do_sweep("b2b_second", 1'b1, -1, 1'b0);
   endtask

   task automatic test_random();
      for (int r = 0; r < 4; r++) begin
         dut_tbl = NV'($urandom);
         do_sweep("random", 1'b0, -1, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_correct();
      test_stuck0();
      test_and_gate();
      test_start_while_busy();
      test_reset_mid_sweep();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
